// File: rtl/eth_bringup_seq.sv
// Power-up / re-init sequencer for the RGMII Ethernet path: times the PHY hardware
// reset, brings up IDELAYCTRL with timeout/retry, waits for PHY settle, then flags ready.
module eth_bringup_seq #(
    parameter int PHY_RST_CYCLES = 2_000_000,
    parameter int PHY_SETTLE_CYC = 10_000_000,
    parameter int RDY_TIMEOUT    = 4096,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_W          = 24
) (
    input  logic       clk_200m,
    input  logic       rstn,
    input  logic       reinit_req,
    input  logic       idelayctrl_rdy,
    output logic       phy_rstn,
    output logic       idelay_ctl_rst,
    output logic       eth_ready,
    output logic       init_fault,
    output logic [2:0] state_o,
    output logic [7:0] retry_cnt
);

    typedef enum logic [2:0] {
        ST_PHY_RST  = 3'd0,
        ST_IDC_WAIT = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_READY    = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PHY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(RDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PHY_SETTLE_CYC - 1);
    localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRY);

    state_t           state_r;
    state_t           nxt_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] nxt_cnt_s;
    logic [7:0]       retry_r;
    logic [7:0]       nxt_retry_s;
    logic             rdy_meta_r;
    logic             rdy_sync_r;
    logic             phy_rstn_r;
    logic             idc_rst_r;
    logic             eth_ready_r;
    logic             init_fault_r;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'd255) ? 8'd255 : v + 8'd1;
    endfunction

    // Two-flop synchronizer for the asynchronous IDELAYCTRL ready flag
    always_ff @(posedge clk_200m) begin
        if (!rstn) begin
            rdy_meta_r <= 1'b0;
            rdy_sync_r <= 1'b0;
        end else begin
            rdy_meta_r <= idelayctrl_rdy;
            rdy_sync_r <= rdy_meta_r;
        end
    end

    // Next-state, counter and retry logic; reinit_req overrides everything but rstn
    always_comb begin
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_r;
        nxt_retry_s = retry_r;
        if (reinit_req) begin
            nxt_state_s = ST_PHY_RST;
            nxt_cnt_s   = CNT_ZERO;
            nxt_retry_s = 8'd0;
        end else begin
            case (state_r)
                ST_PHY_RST: begin
                    if (cnt_r == RST_LAST) begin
                        nxt_state_s = ST_IDC_WAIT;
                        nxt_cnt_s   = CNT_ZERO;
                    end else begin
                        nxt_cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_IDC_WAIT: begin
                    // A ready flag arriving in the timeout cycle still counts as success
                    if (rdy_sync_r) begin
                        nxt_state_s = ST_SETTLE;
                        nxt_cnt_s   = CNT_ZERO;
                    end else if (cnt_r == TMO_LAST) begin
                        nxt_retry_s = sat_inc8(retry_r);
                        nxt_cnt_s   = CNT_ZERO;
                        if (sat_inc8(retry_r) >= RETRY_LIMIT) begin
                            nxt_state_s = ST_FAULT;
                        end else begin
                            nxt_state_s = ST_PHY_RST;
                        end
                    end else begin
                        nxt_cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (!rdy_sync_r) begin
                        nxt_state_s = ST_IDC_WAIT;
                        nxt_cnt_s   = CNT_ZERO;
                    end else if (cnt_r == SETTLE_LAST) begin
                        nxt_state_s = ST_READY;
                        nxt_cnt_s   = CNT_ZERO;
                    end else begin
                        nxt_cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_READY: begin
                    // Losing ready only re-waits for IDELAYCTRL; the PHY keeps running
                    if (!rdy_sync_r) begin
                        nxt_state_s = ST_IDC_WAIT;
                        nxt_cnt_s   = CNT_ZERO;
                    end else begin
                        nxt_cnt_s = CNT_ZERO;
                    end
                end
                ST_FAULT: begin
                    nxt_cnt_s = CNT_ZERO;
                end
                default: begin
                    nxt_state_s = ST_PHY_RST;
                    nxt_cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // State register with outputs decoded from the next state so they move with it
    always_ff @(posedge clk_200m) begin
        if (!rstn) begin
            state_r      <= ST_PHY_RST;
            cnt_r        <= CNT_ZERO;
            retry_r      <= 8'd0;
            phy_rstn_r   <= 1'b0;
            idc_rst_r    <= 1'b1;
            eth_ready_r  <= 1'b0;
            init_fault_r <= 1'b0;
        end else begin
            state_r      <= nxt_state_s;
            cnt_r        <= nxt_cnt_s;
            retry_r      <= nxt_retry_s;
            phy_rstn_r   <= !((nxt_state_s == ST_PHY_RST) || (nxt_state_s == ST_FAULT));
            idc_rst_r    <= (nxt_state_s == ST_PHY_RST) || (nxt_state_s == ST_FAULT);
            eth_ready_r  <= (nxt_state_s == ST_READY);
            init_fault_r <= (nxt_state_s == ST_FAULT);
        end
    end

    assign phy_rstn       = phy_rstn_r;
    assign idelay_ctl_rst = idc_rst_r;
    assign eth_ready      = eth_ready_r;
    assign init_fault     = init_fault_r;
    assign state_o        = state_r;
    assign retry_cnt      = retry_r;

endmodule

// File: tb/tb_eth_bringup_seq.sv
// Directed bench for eth_bringup_seq with shortened timing parameters:
// a per-step vector table plus hand-timed sequences for edge-exact corner cases.
module tb_eth_bringup_seq;

    logic       clk_200m = 1'b0;
    logic       rstn;
    logic       reinit_req;
    logic       idelayctrl_rdy;
    logic       phy_rstn;
    logic       idelay_ctl_rst;
    logic       eth_ready;
    logic       init_fault;
    logic [2:0] state_o;
    logic [7:0] retry_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rstn;
        logic       reinit;
        logic       rdy;
        int         cyc;
        logic [2:0] st;
        logic       phy;
        logic       idc;
        logic       eth;
        logic       flt;
        logic [7:0] rty;
    } vec_t;

    vec_t vecs[$];

    eth_bringup_seq #(
        .PHY_RST_CYCLES(8),
        .PHY_SETTLE_CYC(16),
        .RDY_TIMEOUT(32),
        .MAX_RETRY(2),
        .CNT_W(24)
    ) dut (
        .clk_200m(clk_200m),
        .rstn(rstn),
        .reinit_req(reinit_req),
        .idelayctrl_rdy(idelayctrl_rdy),
        .phy_rstn(phy_rstn),
        .idelay_ctl_rst(idelay_ctl_rst),
        .eth_ready(eth_ready),
        .init_fault(init_fault),
        .state_o(state_o),
        .retry_cnt(retry_cnt)
    );

    always #5 clk_200m = ~clk_200m;

    task automatic add(input logic r, input logic ri, input logic rd, input int c,
                       input logic [2:0] s, input logic p, input logic i, input logic e,
                       input logic f, input logic [7:0] t);
        vec_t v;
        v.rstn = r; v.reinit = ri; v.rdy = rd; v.cyc = c;
        v.st = s; v.phy = p; v.idc = i; v.eth = e; v.flt = f; v.rty = t;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s #%0d got=%0d expected=%0d", name, idx, act, exp);
        end
    endtask

    initial begin
        int phy_rise;
        int eth_rise;
        int fall_at;
        int back_at;
        int phy_low_seen;

        rstn = 1'b0;
        reinit_req = 1'b0;
        idelayctrl_rdy = 1'b1;

        // Each step: drive inputs, run cyc edges, compare all outputs.
        //   rstn rein rdy cyc  st phy idc eth flt rty
        add(1'b0, 1'b0, 1'b1, 5,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0); // reset values
        add(1'b1, 1'b0, 1'b1, 7,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0); // edge 7: still PHY_RST
        add(1'b1, 1'b0, 1'b1, 1,  3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); // edge 8: IDC_WAIT
        add(1'b1, 1'b0, 1'b1, 1,  3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); // edge 9: SETTLE
        add(1'b1, 1'b0, 1'b1, 15, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); // edge 24
        add(1'b1, 1'b0, 1'b1, 1,  3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0); // edge 25: READY
        add(1'b0, 1'b0, 1'b0, 2,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0); // reset, rdy now 0
        add(1'b1, 1'b0, 1'b0, 8,  3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); // edge 8
        add(1'b1, 1'b0, 1'b0, 31, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); // edge 39
        add(1'b1, 1'b0, 1'b0, 1,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1); // edge 40: 1st timeout
        add(1'b1, 1'b0, 1'b0, 8,  3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1); // edge 48
        add(1'b1, 1'b0, 1'b0, 31, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1); // edge 79
        add(1'b1, 1'b0, 1'b0, 1,  3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2); // edge 80: FAULT
        add(1'b1, 1'b0, 1'b0, 10, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2); // held
        add(1'b1, 1'b0, 1'b1, 3,  3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2); // rdy alone can't leave
        add(1'b1, 1'b1, 1'b1, 1,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0); // reinit clears
        add(1'b1, 1'b0, 1'b1, 7,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1'b1, 1,  3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1'b1, 1,  3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1'b1, 15, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1'b1, 1,  3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0); // reinit+25: READY
        add(1'b1, 1'b0, 1'b1, 5,  3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        add(1'b1, 1'b1, 1'b1, 1,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0); // reinit from READY
        add(1'b0, 1'b0, 1'b1, 1,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1'b1, 15, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); // mid-SETTLE
        add(1'b0, 1'b0, 1'b1, 1,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0); // rstn wins

        @(negedge clk_200m);
        foreach (vecs[k]) begin
            rstn = vecs[k].rstn;
            reinit_req = vecs[k].reinit;
            idelayctrl_rdy = vecs[k].rdy;
            repeat (vecs[k].cyc) @(posedge clk_200m);
            @(negedge clk_200m);
            check("vec_state", k, int'(state_o), int'(vecs[k].st));
            check("vec_phy_rstn", k, int'(phy_rstn), int'(vecs[k].phy));
            check("vec_idc_rst", k, int'(idelay_ctl_rst), int'(vecs[k].idc));
            check("vec_eth_ready", k, int'(eth_ready), int'(vecs[k].eth));
            check("vec_init_fault", k, int'(init_fault), int'(vecs[k].flt));
            check("vec_retry_cnt", k, int'(retry_cnt), int'(vecs[k].rty));
        end

        // Edge-exact bring-up timing from reset release with rdy held high
        @(negedge clk_200m);
        rstn = 1'b0; reinit_req = 1'b0; idelayctrl_rdy = 1'b1;
        repeat (3) @(posedge clk_200m);
        @(negedge clk_200m);
        rstn = 1'b1;
        phy_rise = -1;
        eth_rise = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk_200m);
            #1;
            if (phy_rstn && phy_rise < 0) phy_rise = i;
            if (eth_ready && eth_rise < 0) eth_rise = i;
        end
        check("t1_phy_rise_edge", 1, phy_rise, 8);
        check("t1_eth_ready_edge", 1, eth_rise, 25);

        // Drop rdy for 4 cycles while READY: 2 sync + 1 to fall, 1 + 16 settle to return
        @(negedge clk_200m);
        idelayctrl_rdy = 1'b0;
        fall_at = -1;
        back_at = -1;
        phy_low_seen = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_200m);
            #1;
            if (!phy_rstn) phy_low_seen = 1;
            if (!eth_ready && fall_at < 0) fall_at = i;
            if (eth_ready && fall_at > 0 && back_at < 0) back_at = i;
            if (i == 4) idelayctrl_rdy = 1'b1;
        end
        check("t4_eth_fall_edge", 4, fall_at, 3);
        check("t4_eth_back_edge", 4, back_at, 23);
        check("t4_phy_stayed_high", 4, phy_low_seen, 0);
        check("t4_retry_unchanged", 4, int'(retry_cnt), 0);

        // rdy_s arrives exactly at the timeout count (cnt==31 sampled at edge 40)
        for (int variant = 0; variant < 3; variant++) begin
            @(negedge clk_200m);
            rstn = 1'b0; reinit_req = 1'b0; idelayctrl_rdy = 1'b0;
            repeat (2) @(posedge clk_200m);
            @(negedge clk_200m);
            rstn = 1'b1;
            repeat (37) @(posedge clk_200m);
            #1;
            if (variant != 2) idelayctrl_rdy = 1'b1;
            @(posedge clk_200m);
            #1;
            if (variant == 2) idelayctrl_rdy = 1'b1;
            @(posedge clk_200m);
            #1;
            check("t5_state_before_tmo", variant, int'(state_o), 1);
            if (variant == 1) reinit_req = 1'b1;
            @(posedge clk_200m);
            #1;
            reinit_req = 1'b0;
            if (variant == 0) begin
                check("t5_rdy_wins_state", variant, int'(state_o), 2);
                check("t5_rdy_wins_retry", variant, int'(retry_cnt), 0);
            end else if (variant == 1) begin
                check("t5_reinit_wins_state", variant, int'(state_o), 0);
                check("t5_reinit_wins_retry", variant, int'(retry_cnt), 0);
                check("t5_reinit_wins_phy", variant, int'(phy_rstn), 0);
            end else begin
                check("t5_late_rdy_state", variant, int'(state_o), 0);
                check("t5_late_rdy_retry", variant, int'(retry_cnt), 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
